// File: rtl/if_stage_ib.sv
// Instruction-fetch stage with an in-order instruction buffer, redirect cancellation and ADEF flagging.
// Optional IF_IB_BYPASS_EN forwards a returning word straight to ID when it is the IB head.
module if_stage_ib #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          IB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  input  logic [32:0] br_bus,
  input  logic        ex_flush,
  input  logic [31:0] ex_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  localparam int AW = $clog2(IB_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(IB_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] read_q, read_d;
  logic [PW-1:0] cancel_q, cancel_d;
  logic          halt_q, halt_d;

  logic [31:0] pc_mem   [IB_DEPTH];
  logic [31:0] inst_mem [IB_DEPTH];
  logic        adef_mem [IB_DEPTH];

  logic          br_taken;
  logic [31:0]   br_target;
  logic [31:0]   new_pc;
  logic          redirect;
  logic [PW-1:0] in_use;
  logic          fetch_ok;
  logic          adef_push;
  logic          hs;
  logic          dok_live;
  logic          dok_drop;
  logic          head_filled;
  logic          bypass;
  logic          pop;
  logic [AW-1:0] head_idx;
  logic [AW-1:0] alloc_idx;
  logic [AW-1:0] fill_idx;
  logic [31:0]   head_inst;
  logic          head_adef;

  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];
  assign redirect  = ex_flush | br_taken;
  assign new_pc    = ex_flush ? ex_target : br_target;

  assign in_use    = alloc_q - read_q;
  assign fetch_ok  = resetn & ~redirect & ~halt_q & (cancel_q == '0) & (in_use != DEPTH_P);
  assign inst_req  = fetch_ok & (pc_q[1:0] == 2'b00);
  assign inst_addr = pc_q;
  assign adef_push = fetch_ok & (pc_q[1:0] != 2'b00);
  assign hs        = inst_req & inst_addr_ok;

  // Responses still owed to requests issued before the last redirect are swallowed here.
  assign dok_live  = inst_data_ok & ~redirect & (cancel_q == '0);
  assign dok_drop  = inst_data_ok & ~redirect & (cancel_q != '0);

  assign head_idx    = read_q[AW-1:0];
  assign alloc_idx   = alloc_q[AW-1:0];
  assign fill_idx    = fill_q[AW-1:0];
  assign head_filled = (fill_q != read_q);

`ifdef IF_IB_BYPASS_EN
  assign bypass = dok_live & (fill_q == read_q);
`else
  assign bypass = 1'b0;
`endif

  assign head_inst      = bypass ? inst_rdata : inst_mem[head_idx];
  assign head_adef      = bypass ? 1'b0 : adef_mem[head_idx];
  assign fs_to_ds_valid = resetn & ~redirect & (head_filled | bypass);
  assign fs_to_ds_bus   = fs_to_ds_valid ? {head_adef, pc_mem[head_idx], head_inst} : '0;
  assign pop            = fs_to_ds_valid & ds_allowin;

  always_comb begin
    pc_d     = pc_q;
    alloc_d  = alloc_q;
    fill_d   = fill_q;
    read_d   = read_q;
    cancel_d = cancel_q;
    halt_d   = halt_q;
    if (redirect) begin
      pc_d     = new_pc;
      alloc_d  = '0;
      fill_d   = '0;
      read_d   = '0;
      halt_d   = 1'b0;
      cancel_d = cancel_q + (alloc_q - fill_q) - PW'(inst_data_ok);
    end else begin
      if (hs) begin
        alloc_d = alloc_q + PW'(1);
        pc_d    = pc_q + 32'd4;
      end
      if (adef_push) begin
        alloc_d = alloc_q + PW'(1);
        fill_d  = fill_q + PW'(1);
        halt_d  = 1'b1;
      end
      if (dok_live) fill_d = fill_q + PW'(1);
      if (dok_drop) cancel_d = cancel_q - PW'(1);
      if (pop)      read_d = read_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q     <= RESET_PC;
      alloc_q  <= '0;
      fill_q   <= '0;
      read_q   <= '0;
      cancel_q <= '0;
      halt_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      alloc_q  <= alloc_d;
      fill_q   <= fill_d;
      read_q   <= read_d;
      cancel_q <= cancel_d;
      halt_q   <= halt_d;
    end
  end

  // Entry payload needs no reset: validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    if (hs) begin
      pc_mem[alloc_idx]   <= pc_q;
      adef_mem[alloc_idx] <= 1'b0;
    end else if (adef_push) begin
      pc_mem[alloc_idx]   <= pc_q;
      adef_mem[alloc_idx] <= 1'b1;
      inst_mem[alloc_idx] <= '0;
    end
    if (dok_live) inst_mem[fill_idx] <= inst_rdata;
  end

  a_no_orphan_data_ok : assert property (@(posedge clk) disable iff (!resetn)
    inst_data_ok |-> ((cancel_q != '0) || (alloc_q != fill_q)));

endmodule

// File: tb/tb_if_stage_ib.sv
// Directed bench for if_stage_ib: bus responder model plus an expected-fetch scoreboard.
module tb_if_stage_ib;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
`ifdef IF_IB_BYPASS_EN
  localparam int EXP_LAT = 0;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        clk;
  logic        resetn;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic [32:0] br_bus;
  logic        ex_flush;
  logic [31:0] ex_target;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  if_stage_ib #(.RESET_PC(RESET_PC), .IB_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .br_bus(br_bus), .ex_flush(ex_flush), .ex_target(ex_target),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  typedef struct {
    bit          adef;
    logic [31:0] pc;
  } exp_t;

  pend_t pend[$];
  exp_t  exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  bit addr_en = 0;
  bit bus_en = 0;
  logic [31:0] exp_addr = RESET_PC;

  bit obs_req, obs_valid, obs_hs;
  bit seen_hs, seen_dok, seen_valid;
  int first_hs_cyc, first_dok_cyc, first_valid_cyc, mark_cyc;
  logic [31:0] first_hs_addr;
  int hs_cnt, pop_cnt, adef_cnt;

  function automatic logic [31:0] f_data(input logic [31:0] a);
    return a ^ 32'ha5a5_0f0f;
  endfunction

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    seen_hs = 0; seen_dok = 0; seen_valid = 0;
    hs_cnt = 0; pop_cnt = 0; adef_cnt = 0;
    mark_cyc = cyc_n;
  endtask

  // One clock cycle: drive bus inputs at negedge, observe 1 time unit later, update scoreboard.
  task automatic cyc();
    pend_t p;
    exp_t e;
    int stale_n;
    logic redir;
    logic [31:0] npc;
    inst_addr_ok = addr_en;
    inst_data_ok = bus_en && (pend.size() > 0) && (pend[0].due <= cyc_n);
    inst_rdata   = inst_data_ok ? f_data(pend[0].addr) : $urandom;
    #1;
    redir = ex_flush | br_bus[32];
    npc   = ex_flush ? ex_target : br_bus[31:0];
    stale_n = 0;
    foreach (pend[i]) if (pend[i].stale) stale_n++;
    obs_req   = inst_req;
    obs_valid = fs_to_ds_valid;
    obs_hs    = inst_req && inst_addr_ok;
    if (obs_hs) begin
      chk("fetch_addr", 65'(inst_addr), 65'(exp_addr));
      chk("req_while_stale", 65'(stale_n), 65'(0));
      if (!seen_hs) begin
        seen_hs = 1; first_hs_addr = inst_addr; first_hs_cyc = cyc_n;
      end
      hs_cnt++;
      pend.push_back('{addr: inst_addr, due: cyc_n + 1, stale: 1'b0});
      exp_q.push_back('{adef: 1'b0, pc: inst_addr});
      exp_addr = exp_addr + 32'd4;
    end
    if (inst_data_ok) begin
      if (!seen_dok) begin seen_dok = 1; first_dok_cyc = cyc_n; end
      p = pend.pop_front();
    end
    if (fs_to_ds_valid && !seen_valid) begin
      seen_valid = 1; first_valid_cyc = cyc_n;
    end
    if (fs_to_ds_valid && ds_allowin) begin
      chk("id_expected", 65'(exp_q.size() != 0), 65'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("id_bus", fs_to_ds_bus, {e.adef, e.pc, (e.adef ? 32'h0 : f_data(e.pc))});
        pop_cnt++;
        if (e.adef) adef_cnt++;
      end
    end
    if (redir) begin
      chk("redir_req", 65'(inst_req), 65'(0));
      chk("redir_valid", 65'(fs_to_ds_valid), 65'(0));
      exp_q.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_addr = npc;
      if (npc[1:0] != 2'b00) exp_q.push_back('{adef: 1'b1, pc: npc});
    end
    @(posedge clk);
    @(negedge clk);
    ex_flush = 1'b0;
    br_bus   = '0;
    cyc_n++;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    inst_addr_ok = 1'b1;
    inst_data_ok = 1'b1;
    ds_allowin = 1'b1;
    inst_rdata = 32'hdeadbeef;
    #1;
    chk("rst_req", 65'(inst_req), 65'(0));
    chk("rst_valid", 65'(fs_to_ds_valid), 65'(0));
    chk("rst_bus", fs_to_ds_bus, 65'(0));
    pend.delete();
    exp_q.delete();
    exp_addr = RESET_PC;
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_req", 65'(inst_req), 65'(0));
    inst_data_ok = 1'b0;
    resetn = 1'b1;
  endtask

  task automatic drain();
    addr_en = 0; bus_en = 1; ds_allowin = 1'b1;
    repeat (8) cyc();
    chk("drain_idle", 65'(obs_valid), 65'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; ds_allowin = 1'b0; br_bus = '0; ex_flush = 1'b0; ex_target = '0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    do_reset();

    // 1: streaming fetch from reset
    addr_en = 1; bus_en = 1; ds_allowin = 1'b1;
    mark();
    repeat (4) cyc();
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk("t1_steady_valid", 65'(obs_valid), 65'(1));
    end
    chk("t1_first_addr", 65'(first_hs_addr), 65'(RESET_PC));
    chk("t1_first_hs_cyc", 65'(first_hs_cyc), 65'(mark_cyc));
    chk("t1_valid_latency", 65'(first_valid_cyc - first_dok_cyc), 65'(EXP_LAT));
    chk("t1_pop_cnt", 65'(pop_cnt), 65'(20 - 1 - EXP_LAT));

    // 2: ID stalled fills the buffer, then drains
    do_reset();
    ds_allowin = 1'b0; addr_en = 1; bus_en = 1;
    mark();
    repeat (10) cyc();
    chk("t2_hs_cnt", 65'(hs_cnt), 65'(4));
    chk("t2_req_off", 65'(obs_req), 65'(0));
    ds_allowin = 1'b1;
    mark();
    for (int i = 0; i < 10 && !seen_hs; i++) cyc();
    chk("t2_resume_seen", 65'(seen_hs), 65'(1));
    chk("t2_resume_addr", 65'(first_hs_addr), 65'(32'h1c000010));
    chk("t2_resume_cyc", 65'(first_hs_cyc), 65'(mark_cyc + 1));
    repeat (8) cyc();

    // 3: branch with three requests outstanding
    drain();
    bus_en = 0; addr_en = 1;
    mark();
    repeat (3) cyc();
    chk("t3_outstanding", 65'(hs_cnt), 65'(3));
    br_bus = {1'b1, 32'h1c000100};
    cyc();
    bus_en = 1;
    mark();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_no_req_cancel", 65'(obs_req), 65'(0));
      chk("t3_no_stale_valid", 65'(obs_valid), 65'(0));
    end
    for (int i = 0; i < 4 && !seen_hs; i++) cyc();
    chk("t3_resume_seen", 65'(seen_hs), 65'(1));
    chk("t3_resume_addr", 65'(first_hs_addr), 65'(32'h1c000100));
    chk("t3_resume_cyc", 65'(first_hs_cyc), 65'(mark_cyc + 3));
    repeat (6) cyc();

    // 4: exception and branch together, response lands in the redirect cycle
    drain();
    addr_en = 1; bus_en = 1;
    cyc();
    ex_flush = 1'b1; ex_target = 32'h1c000200; br_bus = {1'b1, 32'h1c000300};
    cyc();
    mark();
    cyc();
    chk("t4_resume_now", 65'(obs_hs), 65'(1));
    chk("t4_resume_addr", 65'(first_hs_addr), 65'(32'h1c000200));
    repeat (6) cyc();

    // 5: misaligned branch target raises ADEF and halts fetch
    drain();
    addr_en = 1; bus_en = 1;
    br_bus = {1'b1, 32'h1c000102};
    cyc();
    mark();
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t5_no_req", 65'(obs_req), 65'(0));
    end
    chk("t5_adef_pops", 65'(adef_cnt), 65'(1));
    chk("t5_total_pops", 65'(pop_cnt), 65'(1));
    ex_flush = 1'b1; ex_target = 32'h1c000400;
    cyc();
    mark();
    cyc();
    chk("t5_resume_now", 65'(obs_hs), 65'(1));
    chk("t5_resume_addr", 65'(first_hs_addr), 65'(32'h1c000400));
    repeat (6) cyc();

    // 6: reset with two buffered and two outstanding
    drain();
    ds_allowin = 1'b0; addr_en = 1; bus_en = 1;
    mark();
    cyc(); cyc();
    addr_en = 0;
    cyc();
    addr_en = 1; bus_en = 0;
    cyc(); cyc();
    chk("t6_inflight", 65'(hs_cnt), 65'(4));
    chk("t6_valid_before", 65'(obs_valid), 65'(1));
    do_reset();
    addr_en = 1; bus_en = 1; ds_allowin = 1'b1;
    mark();
    repeat (6) cyc();
    chk("t6_restart_addr", 65'(first_hs_addr), 65'(RESET_PC));
    chk("t6_restart_cyc", 65'(first_hs_cyc), 65'(mark_cyc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
